// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the stages downstream of it.
// Holds the bubble word, halt opcode, opcode field position and the IF/ID bundle.
package if_fetch_stage_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam logic [6:0]  HALT_OPCODE = 7'b1111111;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   valid;
  } ifid_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: PC/hazard inputs, instruction memory port and IF/ID outputs.
// The fetch stage takes the master side, its environment the slave side.
interface if_fetch_stage_if #(
  parameter int pc_width    = 32,
  parameter int instr_width = 32
);

  logic [pc_width-1:0]    pc_in;
  logic                   stall;
  logic                   flush;
  logic [instr_width-1:0] imem_rdata;
  logic [pc_width-1:0]    imem_addr;
  logic                   imem_en;
  logic                   pc_hold;
  logic [instr_width-1:0] ifid_instr;
  logic [pc_width-1:0]    ifid_pc;
  logic                   ifid_valid;
  logic [6:0]             opcode;
  logic                   halt;

  modport master (
    input  pc_in, stall, flush, imem_rdata,
    output imem_addr, imem_en, pc_hold, ifid_instr, ifid_pc, ifid_valid, opcode, halt
  );

  modport slave (
    output pc_in, stall, flush, imem_rdata,
    input  imem_addr, imem_en, pc_hold, ifid_instr, ifid_pc, ifid_valid, opcode, halt
  );

endinterface

// File: rtl/if_fetch_stage_skid.sv
// One-entry holding register for a fetched word that arrives while IF/ID is stalled.
// Clear has priority over load.
module fetch_skid_buf #(
  parameter int pc_width    = 32,
  parameter int instr_width = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic [instr_width-1:0] d_instr,
  input  logic [pc_width-1:0]    d_pc,
  output logic [instr_width-1:0] q_instr,
  output logic [pc_width-1:0]    q_pc,
  output logic                   q_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues 1-cycle-latency imem reads for pc_in and fills IF/ID,
// with stall, flush, a one-entry skid buffer and a sticky halt on HALT_OPCODE.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int pc_width    = PC_WIDTH,
  parameter int instr_width = INSTR_WIDTH
) (
  input  logic                clk,
  input  logic                pc_rst_n,
  if_fetch_stage_if.master    bus
);

  localparam logic [instr_width-1:0] NOP_WORD = instr_width'(NOP_INSTR);

  logic                   req_q;
  logic [pc_width-1:0]    req_pc_q;
  logic [instr_width-1:0] ifid_instr_q;
  logic [pc_width-1:0]    ifid_pc_q;
  logic                   ifid_valid_q;
  logic                   halt_q;

  logic                   skid_valid;
  logic [instr_width-1:0] skid_instr;
  logic [pc_width-1:0]    skid_pc;
  logic                   skid_load;
  logic                   skid_clear;

  logic                   load_en;
  logic [instr_width-1:0] load_instr;
  logic [pc_width-1:0]    load_pc;
  logic                   fetch_en;

  assign fetch_en       = !halt_q && !bus.stall && !skid_valid && pc_rst_n;
  assign bus.imem_en    = fetch_en;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.pc_hold    = bus.stall | skid_valid | halt_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.opcode     = ifid_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.halt       = halt_q;

  // Pick what IF/ID would load on a free edge: the parked skid word first, then the live read.
  always_comb begin
    load_en    = 1'b0;
    load_instr = skid_instr;
    load_pc    = skid_pc;
    skid_load  = !bus.flush && !halt_q && bus.stall && req_q && !skid_valid;
    skid_clear = bus.flush || (skid_valid && !bus.stall && !halt_q);
    if (!bus.flush && !halt_q && !bus.stall) begin
      if (skid_valid) begin
        load_en = 1'b1;
      end else if (req_q) begin
        load_en    = 1'b1;
        load_instr = bus.imem_rdata;
        load_pc    = req_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      req_q    <= fetch_en && !bus.flush;
      req_pc_q <= bus.pc_in;
    end
  end

  // Once halted, IF/ID keeps the halt word until a flush; stall then changes nothing.
  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      ifid_instr_q <= NOP_WORD;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      halt_q       <= 1'b0;
    end else if (bus.flush) begin
      ifid_instr_q <= NOP_WORD;
      ifid_valid_q <= 1'b0;
    end else if (halt_q || bus.stall) begin
      ifid_instr_q <= ifid_instr_q;
    end else if (load_en) begin
      ifid_instr_q <= load_instr;
      ifid_pc_q    <= load_pc;
      ifid_valid_q <= 1'b1;
      if (load_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
        halt_q <= 1'b1;
      end
    end else begin
      ifid_instr_q <= NOP_WORD;
      ifid_valid_q <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .pc_width   (pc_width),
    .instr_width(instr_width)
  ) u_skid (
    .clk    (clk),
    .rst_n  (pc_rst_n),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_instr(bus.imem_rdata),
    .d_pc   (req_pc_q),
    .q_instr(skid_instr),
    .q_pc   (skid_pc),
    .q_valid(skid_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: the bench plays the PC block and a 1-cycle imem,
// and compares IF/ID, halt and handshake outputs against hand-computed values.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic pc_rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem [0:15];

  if_fetch_stage_if #(.pc_width(32), .instr_width(32)) bus ();

  if_fetch_stage #(.pc_width(32), .instr_width(32)) dut (
    .clk     (clk),
    .pc_rst_n(pc_rst_n),
    .bus     (bus)
  );

  always #3 clk = ~clk;

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr[5:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic valid);
    checkOutput({tag, "_instr"}, bus.ifid_instr, instr);
    checkOutput({tag, "_pc"}, bus.ifid_pc, pc);
    checkOutput({tag, "_valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
  endtask

  // One clock: set stall/flush mid-cycle, act as the PC block, return 1 unit after the edge.
  task automatic applyStimulus(input logic s, input logic f);
    logic adv;
    @(negedge clk);
    bus.stall = s;
    bus.flush = f;
    #1 adv = !bus.pc_hold;
    @(posedge clk);
    #1 if (adv) bus.pc_in = bus.pc_in + 32'd4;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h00000013;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00100113;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h00300193;
    mem[4] = 32'h0000007F;
    mem[5] = 32'h00400213;

    pc_rst_n  = 1'b0;
    bus.pc_in = 32'h0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIfid("rst", 32'h00000013, 32'h0, 1'b0);
    checkOutput("rst_opcode", {25'd0, bus.opcode}, 32'h13);
    checkOutput("rst_imem_en", {31'd0, bus.imem_en}, 32'h0);
    checkOutput("rst_halt", {31'd0, bus.halt}, 32'h0);
    checkOutput("rst_pc_hold", {31'd0, bus.pc_hold}, 32'h0);
    pc_rst_n = 1'b1;

    // Streaming: words appear in IF/ID on the second edge after their PC is presented.
    applyStimulus(1'b0, 1'b0);
    checkOutput("e1_valid", {31'd0, bus.ifid_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkIfid("e2", 32'h00500093, 32'h0, 1'b1);
    checkOutput("e2_opcode", {25'd0, bus.opcode}, 32'h13);
    applyStimulus(1'b0, 1'b0);
    checkIfid("e3", 32'h00100113, 32'h4, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkIfid("e4", 32'h002081B3, 32'h8, 1'b1);
    checkOutput("e4_opcode", {25'd0, bus.opcode}, 32'h33);

    // Reset mid-stream returns outputs at once.
    #1 pc_rst_n = 1'b0;
    bus.pc_in = 32'h0;
    #1;
    checkIfid("mrst", 32'h00000013, 32'h0, 1'b0);
    checkOutput("mrst_imem_en", {31'd0, bus.imem_en}, 32'h0);
    checkOutput("mrst_opcode", {25'd0, bus.opcode}, 32'h13);
    repeat (2) @(posedge clk);
    #1 pc_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("mrst_e1_valid", {31'd0, bus.ifid_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkIfid("mrst_e2", 32'h00500093, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkIfid("mrst_e3", 32'h00100113, 32'h4, 1'b1);

    // Stall three cycles while PC 8 is in flight; its word waits in the skid.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkIfid($sformatf("stall%0d", i), 32'h00100113, 32'h4, 1'b1);
      checkOutput($sformatf("stall%0d_pc_hold", i), {31'd0, bus.pc_hold}, 32'h1);
      checkOutput($sformatf("stall%0d_imem_en", i), {31'd0, bus.imem_en}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0);
    checkIfid("unstall", 32'h002081B3, 32'h8, 1'b1);
    checkOutput("unstall_pc_hold", {31'd0, bus.pc_hold}, 32'h0);
    checkOutput("unstall_imem_en", {31'd0, bus.imem_en}, 32'h1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("bubble_valid", {31'd0, bus.ifid_valid}, 32'h0);
    checkOutput("bubble_instr", bus.ifid_instr, 32'h00000013);

    // Flush with stall while PC 12 is in flight: it must never reach IF/ID.
    applyStimulus(1'b1, 1'b1);
    checkOutput("flush_instr", bus.ifid_instr, 32'h00000013);
    checkOutput("flush_valid", {31'd0, bus.ifid_valid}, 32'h0);
    checkOutput("flush_pc_hold", {31'd0, bus.pc_hold}, 32'h1);
    bus.pc_in = 32'h10;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_flush_valid", {31'd0, bus.ifid_valid}, 32'h0);
    checkOutput("post_flush_instr", bus.ifid_instr, 32'h00000013);

    // Halt word at 0x10.
    applyStimulus(1'b0, 1'b0);
    checkIfid("halt", 32'h0000007F, 32'h10, 1'b1);
    checkOutput("halt_opcode", {25'd0, bus.opcode}, 32'h7F);
    checkOutput("halt_flag", {31'd0, bus.halt}, 32'h1);
    checkOutput("halt_imem_en", {31'd0, bus.imem_en}, 32'h0);
    checkOutput("halt_pc_hold", {31'd0, bus.pc_hold}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 3) == 0, 1'b0);
      checkIfid($sformatf("halted%0d", i), 32'h0000007F, 32'h10, 1'b1);
      checkOutput($sformatf("halted%0d_flag", i), {31'd0, bus.halt}, 32'h1);
      checkOutput($sformatf("halted%0d_imem_en", i), {31'd0, bus.imem_en}, 32'h0);
    end

    // Halt word arriving on a flush edge must not halt.
    #1 pc_rst_n = 1'b0;
    bus.pc_in = 32'h10;
    #1 checkOutput("rst2_halt", {31'd0, bus.halt}, 32'h0);
    repeat (2) @(posedge clk);
    #1 pc_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("fh_halt", {31'd0, bus.halt}, 32'h0);
    checkOutput("fh_valid", {31'd0, bus.ifid_valid}, 32'h0);
    checkOutput("fh_instr", bus.ifid_instr, 32'h00000013);
    bus.pc_in = 32'h14;
    applyStimulus(1'b0, 1'b0);
    checkOutput("fh_e3_valid", {31'd0, bus.ifid_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkIfid("fh_e4", 32'h00400213, 32'h14, 1'b1);
    checkOutput("fh_e4_halt", {31'd0, bus.halt}, 32'h0);
    checkOutput("fh_e4_imem_en", {31'd0, bus.imem_en}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
